// File: rtl/led_bar_anim.sv
// ---------------------------------------------------------------------------
// led_bar_anim
//
// LED-bar animation engine for an N-LED bar. It makes its own step timebase
// and blink for the leading LED, so no separate blink controller is needed.
// It offers four animation modes, run/pause, and a status interface that a
// higher-level sequencer can watch.
//
// Parameters
//   N          number of LEDs (N >= 2)
//   STEP_DIV   clock cycles per animation step (>= 1)
//   BLINK_DIV  clock cycles per blink half-period (>= 1)
//   PW         width of the position index
//
// Ports
//   clk         system clock; all logic runs on its rising edge
//   rst         synchronous, active-high reset
//   en          1 = animation runs; 0 = counters frozen and state held
//   mode        00 fill/drain, 01 chaser, 10 ping-pong, 11 flash all
//   out         LED drive; bit 0 is the first LED
//   pos         index of the current leading LED
//   dir         1 = moving up toward N-1, 0 = moving down
//   cycle_done  one-cycle pulse when a full animation period completes
// ---------------------------------------------------------------------------
module led_bar_anim #(
    parameter int N         = 8,
    parameter int STEP_DIV  = 1000,
    parameter int BLINK_DIV = 100,
    parameter int PW        = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [1:0]    mode,
    output logic [N-1:0]  out,
    output logic [PW-1:0] pos,
    output logic          dir,
    output logic          cycle_done
);

    localparam int SW = (STEP_DIV  > 1) ? $clog2(STEP_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [PW-1:0] POS_LAST   = PW'(N - 1);

    localparam logic [1:0] MODE_FILL  = 2'b00;
    localparam logic [1:0] MODE_CHASE = 2'b01;
    localparam logic [1:0] MODE_PING  = 2'b10;
    localparam logic [1:0] MODE_FLASH = 2'b11;

    typedef enum logic {
        PH_FILL  = 1'b0,
        PH_DRAIN = 1'b1
    } phase_e;

    logic [SW-1:0] step_cnt_q,  step_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q,     blink_d;
    logic [PW-1:0] pos_q,       pos_d;
    logic          dir_q,       dir_d;
    phase_e        phase_q,     phase_d;
    logic [1:0]    mode_q,      mode_d;
    logic          cycle_done_q, cycle_done_d;

    logic tick;
    logic restart;

    assign tick    = en && (step_cnt_q == STEP_LAST);
    // A mode that differs from last cycle's mode restarts the animation,
    // whether or not the animation is running.
    assign restart = (mode != mode_q);

    // ---------------------------------------------------------------------
    // Next-state logic. Priority: mode-change restart, then the step tick.
    // Reset takes precedence in the register block below.
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through
        // this block leaves a _d signal unassigned (that would infer a latch).
        step_cnt_d   = step_cnt_q;
        blink_cnt_d  = blink_cnt_q;
        blink_d      = blink_q;
        pos_d        = pos_q;
        dir_d        = dir_q;
        phase_d      = phase_q;
        mode_d       = mode;
        cycle_done_d = 1'b0;

        if (restart) begin
            step_cnt_d  = '0;
            blink_cnt_d = '0;
            blink_d     = 1'b0;
            pos_d       = '0;
            dir_d       = 1'b1;
            phase_d     = PH_FILL;
        end else if (en) begin
            step_cnt_d = tick ? '0 : step_cnt_q + SW'(1);

            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end

            if (tick) begin
                unique case (mode_q)
                    MODE_FILL: begin
                        if (phase_q == PH_FILL) begin
                            if (pos_q == POS_LAST) begin
                                // Bar is full: stay on the top LED, then drain.
                                phase_d = PH_DRAIN;
                                dir_d   = 1'b0;
                            end else begin
                                pos_d = pos_q + PW'(1);
                            end
                        end else begin
                            if (pos_q == '0) begin
                                phase_d      = PH_FILL;
                                dir_d        = 1'b1;
                                cycle_done_d = 1'b1;
                            end else begin
                                pos_d = pos_q - PW'(1);
                            end
                        end
                    end
                    MODE_CHASE: begin
                        if (pos_q == POS_LAST) begin
                            pos_d        = '0;
                            cycle_done_d = 1'b1;
                        end else begin
                            pos_d = pos_q + PW'(1);
                        end
                    end
                    MODE_PING: begin
                        // dir turns around on the same edge that reaches an end,
                        // so dir already shows the new direction at the end LED.
                        if (dir_q) begin
                            pos_d = pos_q + PW'(1);
                            if (pos_q + PW'(1) == POS_LAST) begin
                                dir_d = 1'b0;
                            end
                        end else begin
                            pos_d = pos_q - PW'(1);
                            if (pos_q == PW'(1)) begin
                                dir_d        = 1'b1;
                                cycle_done_d = 1'b1;
                            end
                        end
                    end
                    MODE_FLASH: begin
                        cycle_done_d = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values computed before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt_q   <= '0;
            blink_cnt_q  <= '0;
            blink_q      <= 1'b0;
            pos_q        <= '0;
            dir_q        <= 1'b1;
            phase_q      <= PH_FILL;
            mode_q       <= mode;
            cycle_done_q <= 1'b0;
        end else begin
            step_cnt_q   <= step_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_q      <= blink_d;
            pos_q        <= pos_d;
            dir_q        <= dir_d;
            phase_q      <= phase_d;
            mode_q       <= mode_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    // ---------------------------------------------------------------------
    // LED decode: purely combinational from registered state, so there is
    // no added latency.
    // ---------------------------------------------------------------------
    always_comb begin
        out = '0;
        for (int i = 0; i < N; i++) begin
            unique case (mode_q)
                MODE_FILL:  out[i] = (PW'(i) < pos_q) || ((PW'(i) == pos_q) && blink_q);
                MODE_CHASE: out[i] = (PW'(i) == pos_q);
                MODE_PING:  out[i] = (PW'(i) == pos_q);
                MODE_FLASH: out[i] = blink_q;
                default:    out[i] = 1'b0;
            endcase
        end
    end

    assign pos        = pos_q;
    assign dir        = dir_q;
    assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_led_bar_anim.sv
// ---------------------------------------------------------------------------
// tb_led_bar_anim
//
// Self-checking bench for led_bar_anim with N=8, STEP_DIV=4, BLINK_DIV=2.
// A behavioural model advances on every rising edge and pushes the expected
// outputs into a scoreboard queue. Each entry is popped and compared 1 ns
// after the edge. Directed checks pin down the key points of each scenario.
// ---------------------------------------------------------------------------
module tb_led_bar_anim;

    localparam int N         = 8;
    localparam int STEP_DIV  = 4;
    localparam int BLINK_DIV = 2;
    localparam int PW        = 3;

    logic          clk;
    logic          rst;
    logic          en;
    logic [1:0]    mode;
    logic [N-1:0]  out;
    logic [PW-1:0] pos;
    logic          dir;
    logic          cycle_done;

    led_bar_anim #(
        .N         (N),
        .STEP_DIV  (STEP_DIV),
        .BLINK_DIV (BLINK_DIV),
        .PW        (PW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .out        (out),
        .pos        (pos),
        .dir        (dir),
        .cycle_done (cycle_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  out;
        logic [PW-1:0] pos;
        logic          dir;
        logic          cd;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    int m_step, m_bcnt, m_blink, m_pos, m_dir, m_drain, m_mode, m_cd;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    endtask

    task automatic model_clear();
        m_step = 0; m_bcnt = 0; m_blink = 0; m_pos = 0;
        m_dir = 1; m_drain = 0; m_cd = 0;
    endtask

    task automatic model_edge(input logic r, input logic e, input logic [1:0] md);
        bit tk;
        if (r) begin
            model_clear();
            m_mode = int'(md);
            return;
        end
        if (int'(md) != m_mode) begin
            model_clear();
            m_mode = int'(md);
            return;
        end
        m_cd = 0;
        if (!e) return;
        tk = (m_step == STEP_DIV - 1);
        m_step = tk ? 0 : m_step + 1;
        if (m_bcnt == BLINK_DIV - 1) begin
            m_bcnt = 0;
            m_blink = 1 - m_blink;
        end else begin
            m_bcnt++;
        end
        if (!tk) return;
        case (m_mode)
            0: begin
                if (!m_drain) begin
                    if (m_pos == N - 1) begin m_drain = 1; m_dir = 0; end
                    else m_pos++;
                end else begin
                    if (m_pos == 0) begin m_drain = 0; m_dir = 1; m_cd = 1; end
                    else m_pos--;
                end
            end
            1: begin
                m_pos = (m_pos + 1) % N;
                if (m_pos == 0) m_cd = 1;
            end
            2: begin
                m_pos = m_dir ? m_pos + 1 : m_pos - 1;
                if (m_pos == N - 1) m_dir = 0;
                if (m_pos == 0) begin m_dir = 1; m_cd = 1; end
            end
            default: m_cd = 1;
        endcase
    endtask

    function automatic logic [N-1:0] model_out();
        case (m_mode)
            0:       return N'((1 << m_pos) - 1) | N'(m_blink << m_pos);
            1, 2:    return N'(1 << m_pos);
            default: return m_blink ? {N{1'b1}} : {N{1'b0}};
        endcase
    endfunction

    // One clock: the model takes the inputs seen at the edge and pushes its
    // expectation; the DUT is sampled 1 ns later against the popped entry.
    task automatic step_cycle();
        exp_t e;
        @(posedge clk);
        model_edge(rst, en, mode);
        e.out = model_out();
        e.pos = PW'(m_pos);
        e.dir = m_dir[0];
        e.cd  = m_cd[0];
        exp_q.push_back(e);
        #1;
        e = exp_q.pop_front();
        check("sb_out", 32'(out), 32'(e.out));
        check("sb_pos", 32'(pos), 32'(e.pos));
        check("sb_dir", 32'(dir), 32'(e.dir));
        check("sb_cd",  32'(cycle_done), 32'(e.cd));
    endtask

    initial begin
        logic [N-1:0]  save_out;
        logic [PW-1:0] save_pos;
        int            rem_exp;
        int            n_edges;

        clk = 1'b0; rst = 1'b1; en = 1'b1; mode = 2'b00;
        m_mode = 0;
        model_clear();

        // Reset held for three edges
        repeat (3) step_cycle();
        check("rst_out", 32'(out), 32'h00);
        check("rst_pos", 32'(pos), 32'd0);
        check("rst_dir", 32'(dir), 32'd1);
        check("rst_cd",  32'(cycle_done), 32'd0);
        rst = 1'b0;

        // Fill/drain: 64 enabled edges make one full period
        for (int k = 1; k <= 64; k++) begin
            step_cycle();
            if (k == 4)  check("fill_pos1",  32'(pos), 32'd1);
            if (k == 12) check("fill_p3_b0", 32'(out), 32'h07);
            if (k == 14) check("fill_p3_b1", 32'(out), 32'h0F);
            if (k == 28) check("fill_top_dir", 32'(dir), 32'd1);
            if (k == 32) begin
                check("drain_pos", 32'(pos), 32'd7);
                check("drain_dir", 32'(dir), 32'd0);
            end
            if (k == 36) check("drain_pos6", 32'(pos), 32'd6);
            if (k == 63) check("fill_cd_early", 32'(cycle_done), 32'd0);
            if (k == 64) begin
                check("fill_cd", 32'(cycle_done), 32'd1);
                check("fill_cd_dir", 32'(dir), 32'd1);
            end
        end

        // Chaser
        mode = 2'b01;
        for (int k = 1; k <= 70; k++) begin
            step_cycle();
            if (k == 1)  check("chase_restart", 32'(out), 32'h01);
            if (k == 5)  check("chase_out2", 32'(out), 32'h02);
            if (k == 29) check("chase_out80", 32'(out), 32'h80);
            if (k == 32) check("chase_cd_early", 32'(cycle_done), 32'd0);
            if (k == 33) begin
                check("chase_wrap", 32'(out), 32'h01);
                check("chase_cd", 32'(cycle_done), 32'd1);
            end
            if (k == 65) check("chase_cd2", 32'(cycle_done), 32'd1);
        end

        // Ping-pong
        mode = 2'b10;
        for (int k = 1; k <= 60; k++) begin
            step_cycle();
            if (k == 29) begin
                check("ping_top_pos", 32'(pos), 32'd7);
                check("ping_top_dir", 32'(dir), 32'd0);
            end
            if (k == 33) check("ping_down", 32'(out), 32'h40);
            if (k == 56) check("ping_cd_early", 32'(cycle_done), 32'd0);
            if (k == 57) begin
                check("ping_cd", 32'(cycle_done), 32'd1);
                check("ping_end_out", 32'(out), 32'h01);
            end
        end

        // Flash all
        mode = 2'b11;
        for (int k = 1; k <= 20; k++) begin
            step_cycle();
            if (k == 1) check("flash_off", 32'(out), 32'h00);
            if (k == 3) check("flash_on", 32'(out), 32'hFF);
            if (k == 5) check("flash_cd", 32'(cycle_done), 32'd1);
            if (k == 6) check("flash_cd_low", 32'(cycle_done), 32'd0);
        end

        // Pause mid-step in fill/drain
        mode = 2'b00;
        repeat (6) step_cycle();
        save_out = out;
        save_pos = PW'(m_pos);
        rem_exp  = STEP_DIV - m_step;
        en = 1'b0;
        repeat (10) step_cycle();
        check("pause_out", 32'(out), 32'(save_out));
        check("pause_pos", 32'(pos), 32'(save_pos));
        en = 1'b1;
        n_edges = 0;
        for (int k = 0; k < 2 * STEP_DIV; k++) begin
            step_cycle();
            n_edges++;
            if (pos != save_pos) break;
        end
        check("resume_edges", 32'(n_edges), 32'(rem_exp));
        check("resume_pos", 32'(pos), 32'(save_pos) + 32'd1);

        // Mode change on the same edge as a tick: restart wins
        for (int k = 0; k < 2 * STEP_DIV; k++) begin
            if (m_step == STEP_DIV - 1) break;
            step_cycle();
        end
        check("pre_tick_pos", 32'(pos), 32'(save_pos) + 32'd1);
        mode = 2'b01;
        step_cycle();
        check("tick_restart_pos", 32'(pos), 32'd0);
        check("tick_restart_out", 32'(out), 32'h01);
        check("tick_restart_cd",  32'(cycle_done), 32'd0);

        // Reset in the middle of the drain phase
        mode = 2'b00;
        for (int k = 1; k <= 40; k++) begin
            step_cycle();
            if (k == 36) check("mid_drain_dir", 32'(dir), 32'd0);
        end
        rst = 1'b1;
        step_cycle();
        check("drain_rst_out", 32'(out), 32'h00);
        check("drain_rst_pos", 32'(pos), 32'd0);
        check("drain_rst_dir", 32'(dir), 32'd1);
        rst = 1'b0;
        repeat (8) step_cycle();
        check("post_rst_pos", 32'(pos), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/led_bar_anim.md
Name: led_bar_anim

Overview:
- Parametrised LED-bar animation engine; successor to the fixed 8-LED fill/drain sequencer.
- Drives an N-bit LED bar and generates its own step timebase and leading-LED blink internally, so no separate blink-controller instance is needed.
- Adds run/pause, four selectable animation modes, and a position/direction/cycle-done status interface for higher-level sequencing.
- Sits between the board clock domain and the LED output pins.

Parameters:
- N, 8, number of LEDs; legal range N >= 2.
- STEP_DIV, 1000, clock cycles per animation step; legal range STEP_DIV >= 1.
- BLINK_DIV, 100, clock cycles per blink half-period; legal range BLINK_DIV >= 1.
- PW, $clog2(N), width of the position index.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  1 = animation runs; 0 = step and blink counters frozen, all state held.
- mode  input  2  animation select:
  - 00 = fill/drain
  - 01 = chaser
  - 10 = ping-pong
  - 11 = flash all
- out  output  N  LED drive; bit 0 is the first LED.
- pos  output  PW  current leading-LED index.
- dir  output  1  1 = moving up (toward N-1), 0 = moving down.
- cycle_done  output  1  one-cycle pulse when a full animation period completes.

Behaviour:
- Reset is synchronous and active-high. When rst=1 at a rising edge, the following take their reset values:
  - step_cnt = 0, blink_cnt = 0, blink = 0
  - pos = 0, dir = 1, phase = FILL, mode_q = mode
  - cycle_done = 0
  - Consequently out = 0 in every mode.
- rst has priority over en and over any mode change.
- Step tick:
  - step_cnt counts 0..STEP_DIV-1 while en=1 and wraps to 0.
  - tick = en && step_cnt == STEP_DIV-1.
  - All pos/dir/phase updates occur on the tick edge.
  - The first tick after reset therefore lands on the STEP_DIV-th enabled edge.
- Blink: blink_cnt counts 0..BLINK_DIV-1 while en=1; blink toggles when blink_cnt == BLINK_DIV-1.
- out is a pure combinational decode of the registered state; there is no extra latency.
- Mode 00, fill/drain (period 2N steps). phase is FILL or DRAIN.
  - FILL: out[i] = 1 for i < pos; out[pos] = blink; all higher bits 0.
    - tick with pos < N-1: pos increments.
    - tick with pos = N-1: phase becomes DRAIN, pos stays N-1, dir becomes 0.
  - DRAIN: same decode as FILL (bits below pos on, out[pos] = blink).
    - tick with pos > 0: pos decrements.
    - tick with pos = 0: phase becomes FILL, pos stays 0, dir becomes 1, cycle_done = 1.
- Mode 01, chaser (period N steps).
  - out = one-hot at pos, solid (no blink).
  - tick: pos increments; N-1 wraps to 0, and the wrap asserts cycle_done.
  - dir stays 1.
- Mode 10, ping-pong (period 2N-2 steps).
  - out = one-hot at pos, solid.
  - tick: pos moves by +1 when dir=1, by -1 when dir=0.
  - When pos reaches N-1 (dir=1), dir flips to 0 on that same edge.
  - When pos reaches 0 (dir=0), dir flips to 1 and cycle_done = 1 on that same edge.
- Mode 11, flash all.
  - out = {N{blink}}; pos and dir are held.
  - Every tick asserts cycle_done.
- Mode change:
  - mode is registered as mode_q every cycle.
  - When mode != mode_q, the next edge performs a restart: step_cnt, blink_cnt, blink, pos all cleared; dir = 1; phase = FILL; cycle_done = 0.
  - This applies regardless of en.
- Pause: en=0 holds every register except mode_q. out stays static, apart from a pending restart caused by a mode change.
- cycle_done is registered, high for exactly one cycle, and never asserted while en=0.
- Simultaneous events, in priority order: rst, then mode-change restart, then tick.

Test Plan:
- Shared bench setup: N=8, STEP_DIV=4, BLINK_DIV=2, mode=00, en=1.
- Reset: hold rst for 3 cycles, then release. Required: out=0x00, pos=0, dir=1, cycle_done=0.
- Fill/drain: run 64 cycles.
  - pos increments every 4 cycles.
  - With pos=3 and blink=1, out=0x0F; with pos=3 and blink=0, out=0x07.
  - After pos=7, pos counts down 7..0.
  - cycle_done pulses once, on the 64th enabled edge, as pos goes from 0 back to FILL.
- Chaser (mode=01): after the 1-cycle restart, out steps 0x01, 0x02, ..., 0x80, 0x01, each held 4 cycles with no blink. cycle_done pulses on the 0x80 to 0x01 wrap, every 32 cycles.
- Ping-pong (mode=10):
  - out sequence 0x01 ... 0x80 ... 0x01.
  - dir reads 0 in the cycle where pos=7 is first visible.
  - cycle_done pulses when pos returns to 0, after 14 steps = 56 cycles.
- Pause/mode edge cases:
  - Drop en for 10 cycles mid-step. Required: out, pos and step phase are unchanged, and the resume completes the remaining step cycles.
  - Switch mode at the same edge as a tick. Required: restart wins and pos=0.
  - Assert rst mid-DRAIN. Required: out=0x00 on the next edge.
